// File: rtl/recursive_adder.sv
// Registered unsigned adder whose carries come from a recursive-doubling (Kogge-Stone) prefix network.
// Optional registered carry-out port enabled by defining RECURSIVE_ADDER_COUT_EN.
module recursive_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
`ifdef RECURSIVE_ADDER_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("recursive_adder: WIDTH must be a power of two, at least 2");
  end

  // gs[k]/ps[k]: group generate/propagate covering 2^k bits ending at each position
  logic [WIDTH-1:0] gs [LEVELS+1];
  logic [WIDTH-1:0] ps [LEVELS];
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;

  assign gs[0] = a & b;
  assign ps[0] = a ^ b;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int unsigned SPAN = 1 << k;
    // Bits below SPAN combine with an implicit (G=0,P=1) identity element
    assign gs[k+1] = gs[k] | (ps[k] & (gs[k] << SPAN));
    if (k + 1 < LEVELS) begin : g_prop
      assign ps[k+1] = ps[k] & ~(~ps[k] << SPAN);
    end
  end

  assign carry = gs[LEVELS] << 1;
  assign sum   = ps[0] ^ carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= sum;
    end
  end

`ifdef RECURSIVE_ADDER_COUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout <= 1'b0;
    end else begin
      cout <= gs[LEVELS][WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_recursive_adder.sv
// Self-checking bench for recursive_adder: directed vectors, async reset checks and
// 10k random pairs against an arithmetic reference model.
module tb_recursive_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, out;
`ifdef RECURSIVE_ADDER_COUT_EN
  logic         cout;
`endif

  logic [W:0]   model;
  bit           chk_en = 1'b0;
  int           checks = 0;
  int           fails  = 0;

  recursive_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
`ifdef RECURSIVE_ADDER_COUT_EN
    ,
    .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain wide addition, captured on each rising edge, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) model = '0;
    else     model = {1'b0, a} + {1'b0, b};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out", out, model[W-1:0]);
`ifdef RECURSIVE_ADDER_COUT_EN
      check("model_cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, model[W]});
`endif
    end
  end

  task automatic directed(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] eo, input logic ec);
    @(negedge clk);
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    check("dir_out", out, eo);
    check("dir_model", model[W-1:0], eo);
`ifdef RECURSIVE_ADDER_COUT_EN
    check("dir_cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, ec});
`else
    if (ec !== model[W]) check("dir_model_carry", {{(W-1){1'b0}}, model[W]}, {{(W-1){1'b0}}, ec});
`endif
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", out, '0);
`ifdef RECURSIVE_ADDER_COUT_EN
    check("reset_cout", {{(W-1){1'b0}}, cout}, '0);
`endif
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge", out, 32'h2345_6789);

    directed(32'h0000_0025, 32'h0000_001D, 32'h0000_0042, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    directed(32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
    directed(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0);
    directed(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);

    // Steady 0x42, then asynchronous reset between edges
    directed(32'h0000_0025, 32'h0000_001D, 32'h0000_0042, 1'b0);
    @(negedge clk);
    check("steady_out", out, 32'h0000_0042);
    #2 rst = 1'b1;
    #1 check("async_rst_out", out, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out", out, 32'h0000_0042);

    // Inputs wiggling between edges must not disturb the registered value
    @(negedge clk);
    a = 32'hDEAD_BEEF;
    #1 check("hold_between_edges", out, 32'h0000_0042);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 check("rand_async_rst", out, '0);
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
